// File: rtl/uart_rx_if.sv
// Serial receive bundle: raw line in, received byte with valid/error pulses out.
// Latency: none, wires only.
// Backpressure: none; dv and frame_err are one-cycle pulses that the consumer must take when they fire.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx;
    logic                  dv;
    logic [DATA_WIDTH-1:0] data;
    logic                  active;
    logic                  frame_err;

    // Line driver / byte consumer side
    modport master (
        output rx,
        input  dv,
        input  data,
        input  active,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  rx,
        output dv,
        output data,
        output active,
        output frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_WIDTH bits LSB first, one stop bit.
// Latency: dv/frame_err registered 2 + HALF_BIT + (DATA_WIDTH+1)*CLK_PER_BIT clocks after rx is first sampled low.
// Backpressure: none; each frame produces a single-cycle dv or frame_err pulse, data holds until the next dv.
module uart_rx #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8
) (
    input logic     clk,
    input logic     arst_n,
    uart_rx_if.slave bus
);
    localparam int CLK_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int HALF_BIT    = CLK_PER_BIT / 2;
    localparam int CW          = $clog2(CLK_PER_BIT);
    localparam int BW          = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Too few clocks per bit leaves no room for a mid-bit sample point
    generate
        if (CLK_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLOCK_RATE/BAUD_RATE must be at least 4");
        end
    endgenerate

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RX_DATA = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    logic                  rx_meta, rx_s;
    state_t                state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dv_q, dv_d;
    logic                  frame_err_q, frame_err_d;
    logic                  active_q, active_d;
    logic                  armed_q, armed_d;

    // Two-flop synchronizer on the asynchronous line; resets to the idle level
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            frame_err_q <= 1'b0;
            active_q    <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            frame_err_q <= frame_err_d;
            active_q    <= active_d;
            armed_q     <= armed_d;
        end
    end

    // Next-state and output decode; pulses default low so they last one cycle
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        frame_err_d = 1'b0;
        active_d    = active_q;
        armed_d     = armed_q;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                // A line held low after a framing error (break) must go high before we re-arm
                if (rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d = RX_DATA;
                    end else begin
                        // Start bit did not survive to mid-bit: treat as a glitch
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rx_s;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    state_d   = CLEANUP;
                    active_d  = 1'b0;
                    if (rx_s) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        armed_d     = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            CLEANUP: begin
                // Leaves mid stop-bit so a following start edge is not missed
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                active_d  = 1'b0;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign bus.dv        = dv_q;
    assign bus.frame_err = frame_err_q;
    assign bus.data      = data_q;
    assign bus.active    = active_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit.
// Latency: expectations derived from the mid-bit sampling rule and fixed frame latency.
// Backpressure: not applicable; the monitor logs every pulse as it happens.
module tb_uart_rx;
    localparam int CLOCK_RATE = 1_843_200;
    localparam int BAUD_RATE  = 115_200;
    localparam int DW         = 8;
    localparam int BIT        = CLOCK_RATE / BAUD_RATE;      // 16
    // Cycle at which a pulse is seen, relative to the cycle rx was driven low
    localparam int LAT        = 3 + BIT / 2 + (DW + 1) * BIT; // 155

    logic clk    = 1'b0;
    logic arst_n = 1'b0;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .DATA_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every pulse with its cycle and record active edges
    int         dv_cyc_q[$];
    logic [7:0] dv_dat_q[$];
    int         fe_cyc_q[$];
    int         rise_cyc = -1;
    int         fall_cyc = -1;
    int         overlap  = 0;
    int         wide     = 0;
    logic       prev_dv  = 1'b0;
    logic       prev_fe  = 1'b0;
    logic       prev_act = 1'b0;

    always @(negedge clk) begin
        if (bus.dv) begin
            dv_cyc_q.push_back(cyc);
            dv_dat_q.push_back(bus.data);
        end
        if (bus.frame_err) fe_cyc_q.push_back(cyc);
        if (bus.dv && bus.frame_err) overlap++;
        if ((bus.dv && prev_dv) || (bus.frame_err && prev_fe)) wide++;
        if (bus.active && !prev_act) rise_cyc = cyc;
        if (!bus.active && prev_act) fall_cyc = cyc;
        prev_dv  = bus.dv;
        prev_fe  = bus.frame_err;
        prev_act = bus.active;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dvc(input int i);
        return (i < dv_cyc_q.size()) ? dv_cyc_q[i] : -1;
    endfunction

    function automatic int dvd(input int i);
        return (i < dv_dat_q.size()) ? int'(dv_dat_q[i]) : -1;
    endfunction

    function automatic int fec(input int i);
        return (i < fe_cyc_q.size()) ? fe_cyc_q[i] : -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        dv_cyc_q.delete();
        dv_dat_q.delete();
        fe_cyc_q.delete();
        rise_cyc = -1;
        fall_cyc = -1;
    endtask

    // Drive one frame with the given bit length; rx is left at the stop level
    task automatic send_frame(input logic [7:0] b, input int bl, input logic stop, output int fall);
        bus.rx = 1'b0;
        fall   = cyc;
        idle(bl);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            idle(bl);
        end
        bus.rx = stop;
        idle(bl);
    endtask

    // Reference: each clean frame yields its byte exactly LAT cycles after the falling edge
    int         exp_cyc_q[$];
    logic [7:0] exp_dat_q[$];
    int         f, f1, f2;
    logic [7:0] b, last_byte;
    int         gap;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx = 1'b1;
        arst_n = 1'b0;
        idle(3);
        check("rst_dv",     bus.dv,        0);
        check("rst_ferr",   bus.frame_err, 0);
        check("rst_active", bus.active,    0);
        check("rst_data",   bus.data,      0);
        arst_n = 1'b1;
        idle(10);

        // Single frame 0xA5
        clear_mon();
        send_frame(8'hA5, BIT, 1'b1, f);
        idle(20);
        check("a5_dv_count", dv_cyc_q.size(), 1);
        check("a5_dv_cyc",   dvc(0), f + LAT);
        check("a5_data",     dvd(0), 8'hA5);
        check("a5_fe_count", fe_cyc_q.size(), 0);
        check("a5_act_rise", rise_cyc, f + 3);
        check("a5_act_fall", fall_cyc, f + LAT);

        // Back-to-back 0x00 then 0xFF
        clear_mon();
        send_frame(8'h00, BIT, 1'b1, f1);
        send_frame(8'hFF, BIT, 1'b1, f2);
        idle(20);
        check("b2b_dv_count", dv_cyc_q.size(), 2);
        check("b2b_spacing",  dvc(1) - dvc(0), 10 * BIT);
        check("b2b_data0",    dvd(0), 8'h00);
        check("b2b_data1",    dvd(1), 8'hFF);

        // Random bytes with random idle gaps (zero gap = back-to-back)
        clear_mon();
        exp_cyc_q.delete();
        exp_dat_q.delete();
        for (int k = 0; k < 10; k++) begin
            b   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 12);
            idle(gap);
            send_frame(b, BIT, 1'b1, f);
            exp_cyc_q.push_back(f + LAT);
            exp_dat_q.push_back(b);
        end
        idle(20);
        check("rnd_dv_count", dv_cyc_q.size(), exp_cyc_q.size());
        for (int k = 0; k < exp_cyc_q.size(); k++) begin
            check("rnd_dv_cyc", dvc(k), exp_cyc_q[k]);
            check("rnd_data",   dvd(k), exp_dat_q[k]);
        end
        check("rnd_fe_count", fe_cyc_q.size(), 0);
        last_byte = exp_dat_q[exp_dat_q.size() - 1];

        // Framing error followed by a long break
        clear_mon();
        send_frame(8'h3C, BIT, 1'b0, f);
        idle(400);
        check("ferr_count",  fe_cyc_q.size(), 1);
        check("ferr_cyc",    fec(0), f + LAT);
        check("ferr_dv",     dv_cyc_q.size(), 0);
        check("ferr_data",   bus.data, last_byte);
        check("ferr_active", bus.active, 0);
        bus.rx = 1'b1;
        idle(30);
        send_frame(8'h11, BIT, 1'b1, f);
        idle(20);
        check("ferr_restart_count", dv_cyc_q.size(), 1);
        check("ferr_restart_data",  dvd(0), 8'h11);
        check("ferr_fe_total",      fe_cyc_q.size(), 1);

        // 5-cycle glitch on an idle line
        clear_mon();
        bus.rx = 1'b0;
        f      = cyc;
        idle(5);
        bus.rx = 1'b1;
        idle(40);
        check("glitch_dv",     dv_cyc_q.size(), 0);
        check("glitch_fe",     fe_cyc_q.size(), 0);
        check("glitch_rise",   rise_cyc, f + 3);
        check("glitch_active", (fall_cyc - rise_cyc > 0) && (fall_cyc - rise_cyc <= 10), 1);

        // Reset during bit 4 of frame 0xF0
        clear_mon();
        bus.rx = 1'b0;
        idle(BIT + 4 * BIT);
        bus.rx = 1'b1;
        idle(4);
        arst_n = 1'b0;
        idle(1);
        check("mrst_dv",     bus.dv,        0);
        check("mrst_ferr",   bus.frame_err, 0);
        check("mrst_active", bus.active,    0);
        check("mrst_data",   bus.data,      0);
        arst_n = 1'b1;
        idle(BIT - 4 + 4 * BIT + 100);
        check("mrst_no_dv", dv_cyc_q.size(), 0);
        check("mrst_no_fe", fe_cyc_q.size(), 0);
        send_frame(8'h5A, BIT, 1'b1, f);
        idle(20);
        check("mrst_next_count", dv_cyc_q.size(), 1);
        check("mrst_next_data",  dvd(0), 8'h5A);

        // Baud mismatch: slow transmitter
        clear_mon();
        send_frame(8'h81, BIT + 1, 1'b1, f);
        idle(30);
        check("slow_count", dv_cyc_q.size(), 1);
        check("slow_data",  dvd(0), 8'h81);
        check("slow_fe",    fe_cyc_q.size(), 0);

        // Baud mismatch: fast transmitter
        clear_mon();
        send_frame(8'hC3, BIT - 1, 1'b1, f);
        idle(30);
        check("fast_count", dv_cyc_q.size(), 1);
        check("fast_data",  dvd(0), 8'hC3);
        check("fast_fe",    fe_cyc_q.size(), 0);

        check("pulse_overlap", overlap, 0);
        check("pulse_wide",    wide,    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_RATE, default 100_000_000: clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200: serial bit rate.
REQ-003 Parameter DATA_WIDTH, default 8: data bits per frame.
REQ-004 clk  input  1  the single clock; all logic on its rising edge.
REQ-005 arst_n  input  1  reset, synchronous and active-low, sampled on rising clk.
REQ-006 rx  input  1  asynchronous serial line; idle high, 8N1-style framing (start 0, DATA_WIDTH bits LSB first, one stop 1).
REQ-007 dv  output  1  one-cycle pulse: frame received with a valid stop bit.
REQ-008 data  output  DATA_WIDTH  last correctly received byte, stable until the next dv.
REQ-009 active  output  1  high while a frame is being received.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-011 CLK_PER_BIT SHALL be CLOCK_RATE/BAUD_RATE (integer division), and HALF_BIT SHALL be CLK_PER_BIT/2; CLK_PER_BIT < 4 SHALL be a compile-time error.
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-013 clk_cnt width SHALL be $clog2(CLK_PER_BIT); bit_cnt SHALL count 0..DATA_WIDTH-1 without overflow.
REQ-014 The FSM SHALL have the states IDLE, START, RX_DATA, STOP and CLEANUP; any other encoding SHALL go to IDLE.
REQ-015 IDLE: clk_cnt=0, bit_cnt=0; if armed and rx_s==0 -> START, else stay.
REQ-016 armed SHALL be set whenever rx_s==1 in IDLE, and cleared on frame_err; this blocks restart on a line held low (break).
REQ-017 START: count HALF_BIT cycles, then sample rx_s at mid start-bit; 0 -> RX_DATA with clk_cnt=0; 1 -> IDLE (glitch rejected, no dv or frame_err).
REQ-018 RX_DATA: each bit lasts CLK_PER_BIT cycles; at clk_cnt==CLK_PER_BIT-1 shift rx_s into the shift register at position bit_cnt (LSB first), clear clk_cnt; after bit DATA_WIDTH-1 -> STOP.
REQ-019 STOP: at clk_cnt==CLK_PER_BIT-1 sample rx_s; 1 -> load data from the shift register and pulse dv; 0 -> pulse frame_err and leave data unchanged; either case -> CLEANUP.
REQ-020 CLEANUP: clear dv/frame_err, -> IDLE after one cycle; the return happens mid stop-bit so back-to-back frames are received.
REQ-021 active SHALL rise on entry to START and fall on entry to CLEANUP; on glitch rejection it falls on return to IDLE.
REQ-022 dv and frame_err SHALL never be high in the same cycle; each is exactly one cycle wide.
REQ-023 Latency: if the first clk edge that samples rx low is edge 0, dv/frame_err are registered at edge 2 + HALF_BIT + (DATA_WIDTH+1)*CLK_PER_BIT.
REQ-024 rx changes during RX_DATA outside the sample instant SHALL have no effect.

Reset
REQ-025 With arst_n low at a rising clk edge: state=IDLE, dv=0, frame_err=0, active=0, data=0, clk_cnt=0, bit_cnt=0, armed=0, and both synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame with no dv or frame_err; reception restarts only after rx_s has been seen high.

Verification (CLOCK_RATE=1_843_200, BAUD_RATE=115_200 -> CLK_PER_BIT=16, DATA_WIDTH=8)
REQ-027 Frame 0xA5 with 16-cycle bits -> dv single pulse registered at edge 154 after the falling edge, data=0xA5, frame_err=0, active high from edge 2 to edge 154.
REQ-028 Back-to-back frames 0x00 then 0xFF, no idle gap -> two dv pulses 160 cycles apart; data=0x00 then 0xFF.
REQ-029 Frame 0x3C with stop bit forced 0, then rx held low for 400 cycles -> one frame_err pulse, no dv, data keeps the previous value, no further frame until rx returns high.
REQ-030 rx low pulse of 5 cycles on an idle line -> START entered, glitch rejected, back to IDLE; no dv/frame_err; active high for <=10 cycles.
REQ-031 arst_n low for 1 cycle during bit 4 of a frame -> all outputs 0 next cycle, no pulse for that frame; the next clean 0x5A frame -> dv with data=0x5A.
REQ-032 Bit period of 15 or 17 cycles (+/-6%) with frame 0x81 -> data=0x81 received correctly.
